// File: rtl/rv32_pkg.sv
// rv32_pkg
//   Shared constants and the pipeline entry record for the ID/EX shift stage.
//   Shifter type encoding: SHT_SRL=00, SHT_SLL=01, SHT_SRA=10.
//   funct3 codes for shifts: F3_SLL=001, F3_SRX=101 (SRL/SRA selected by instr[30]).
package rv32_pkg;

  localparam int RV_XLEN = 32;
  localparam int SHAMT_W = $clog2(RV_XLEN);

  localparam logic [1:0] SHT_SRL = 2'b00;
  localparam logic [1:0] SHT_SLL = 2'b01;
  localparam logic [1:0] SHT_SRA = 2'b10;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // One registered ID/EX entry; used for both the main and the skid slot.
  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] a;
    logic [RV_XLEN-1:0] b;
    logic [4:0]         rd;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         shtype;
  } entry_t;

endpackage

// File: rtl/ex_shift_decode.sv
// ex_shift_decode
//   Combinational pre-decode of shift control for the EX-stage shifter.
//   Ports:
//     funct3    in   3  instruction funct3
//     funct7_b5 in   1  instr[30], selects SRA over SRL
//     is_alu    in   1  OP / OP-IMM instruction
//     b_lo      in   5  low bits of the selected B operand (shift amount source)
//     is_shift  out  1  entry is SLL/SRL/SRA(I)
//     shamt     out  5  shift amount, 0 for non-shift entries
//     shtype    out  2  shifter encoding (SHT_*)
module ex_shift_decode
  import rv32_pkg::*;
(
  input  logic [2:0]         funct3,
  input  logic               funct7_b5,
  input  logic               is_alu,
  input  logic [SHAMT_W-1:0] b_lo,
  output logic               is_shift,
  output logic [SHAMT_W-1:0] shamt,
  output logic [1:0]         shtype
);

  always_comb begin
    is_shift = 1'b0;
    shamt    = '0;
    shtype   = SHT_SRL;
    if (is_alu) begin
      if (funct3 == F3_SLL) begin
        is_shift = 1'b1;
        shamt    = b_lo;
        shtype   = SHT_SLL;
      end else if (funct3 == F3_SRX) begin
        is_shift = 1'b1;
        shamt    = b_lo;
        shtype   = funct7_b5 ? SHT_SRA : SHT_SRL;
      end
    end
  end

endmodule

// File: rtl/id_ex_shift_stage.sv
// id_ex_shift_stage
//   ID/EX pipeline register with valid/ready handshake and a 2-entry (main + skid)
//   buffer. Shift control is pre-decoded at capture so EX drives its shifter directly.
//   Optional feature macro: ID_EX_STALL_CNT_EN adds saturating stall_cnt / flush_cnt.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     flush               drop held and incoming entries
//     in_valid/in_ready   ID-side handshake
//     in_pc, in_rs1_data, in_rs2_data, in_imm, in_rd, in_is_alu, in_use_imm,
//     in_funct3, in_funct7_b5   decoded instruction fields
//     out_valid/out_ready EX-side handshake
//     out_pc, out_a, out_b, out_rd, out_is_shift, out_shamt, out_shtype   EX entry
//     stall_cnt, flush_cnt   (ID_EX_STALL_CNT_EN only) event counters
module id_ex_shift_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            in_is_alu,
  input  logic            in_use_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_b5,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]     stall_cnt,
  output logic [15:0]     flush_cnt,
`endif
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_is_shift,
  output logic [4:0]      out_shamt,
  output logic [1:0]      out_shtype
);

  entry_t main_q, skid_q, cap;
  logic   main_valid, skid_valid;
  logic   in_fire, out_fire;
  logic   dec_is_shift;
  logic [SHAMT_W-1:0] dec_shamt;
  logic [1:0]         dec_shtype;
  logic [XLEN-1:0]    sel_b;

  // Ready depends only on registered state (plus reset), never on out_ready.
  assign in_ready  = ~skid_valid & ~rst;
  assign out_valid = main_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;

  assign sel_b = in_use_imm ? in_imm : in_rs2_data;

  ex_shift_decode u_dec (
    .funct3    (in_funct3),
    .funct7_b5 (in_funct7_b5),
    .is_alu    (in_is_alu),
    .b_lo      (sel_b[SHAMT_W-1:0]),
    .is_shift  (dec_is_shift),
    .shamt     (dec_shamt),
    .shtype    (dec_shtype)
  );

  always_comb begin
    cap          = '0;
    cap.pc       = in_pc;
    cap.a        = in_rs1_data;
    cap.b        = sel_b;
    cap.rd       = in_rd;
    cap.is_shift = dec_is_shift;
    cap.shamt    = dec_shamt;
    cap.shtype   = dec_shtype;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      // Data is left stale; only the valid bits matter after a redirect.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_fire) begin
      if (skid_valid) begin
        // in_ready is low here, so no new entry can arrive this cycle.
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_q <= cap;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid) begin
        main_q     <= cap;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= cap;
        skid_valid <= 1'b1;
      end
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

  assign out_pc       = main_q.pc;
  assign out_a        = main_q.a;
  assign out_b        = main_q.b;
  assign out_rd       = main_q.rd;
  assign out_is_shift = main_q.is_shift;
  assign out_shamt    = main_q.shamt;
  assign out_shtype   = main_q.shtype;

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// tb_id_ex_shift_stage
//   Directed-vector bench for id_ex_shift_stage with hand-computed expectations.
//   Define ID_EX_STALL_CNT_EN to also exercise the stall/flush counters.
module tb_id_ex_shift_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic [31:0] in_imm = '0;
  logic [4:0]  in_rd = '0;
  logic        in_is_alu = 1'b0;
  logic        in_use_imm = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7_b5 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_a, out_b;
  logic [4:0]  out_rd;
  logic        out_is_shift;
  logic [4:0]  out_shamt;
  logic [1:0]  out_shtype;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_shift_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_rd        (in_rd),
    .in_is_alu    (in_is_alu),
    .in_use_imm   (in_use_imm),
    .in_funct3    (in_funct3),
    .in_funct7_b5 (in_funct7_b5),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef ID_EX_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .out_pc       (out_pc),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_rd       (out_rd),
    .out_is_shift (out_is_shift),
    .out_shamt    (out_shamt),
    .out_shtype   (out_shtype)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd, input logic is_alu,
                       input logic use_imm, input logic [2:0] f3, input logic b5);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_rs1_data  = rs1;
    in_rs2_data  = rs2;
    in_imm       = imm;
    in_rd        = rd;
    in_is_alu    = is_alu;
    in_use_imm   = use_imm;
    in_funct3    = f3;
    in_funct7_b5 = b5;
  endtask

  initial begin
    // 1. reset
    rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_shamt", out_shamt, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // 2. SRAI x?, 0x80000000, 5 (imm 0x405 carries instr[30])
    drive(32'h0000_1000, 32'h8000_0000, 32'h0, 32'h0000_0405, 5'd7, 1'b1, 1'b1, 3'b101, 1'b1);
    step();
    in_valid = 1'b0;
    chk("srai_valid", out_valid, 1);
    chk("srai_is_shift", out_is_shift, 1);
    chk("srai_shtype", out_shtype, 2'b10);
    chk("srai_shamt", out_shamt, 5);
    chk("srai_a", out_a, 32'h8000_0000);
    chk("srai_b", out_b, 32'h0000_0405);
    chk("srai_rd", out_rd, 7);
    out_ready = 1'b1;
    step();
    chk("srai_drained", out_valid, 0);

    // Non-shift and funct3=101 without is_alu decode to no shift.
    drive(32'h0000_1004, 32'h1, 32'h2, 32'h0000_001F, 5'd3, 1'b1, 1'b1, 3'b000, 1'b0);
    step();
    chk("add_is_shift", out_is_shift, 0);
    chk("add_shamt", out_shamt, 0);
    chk("add_b", out_b, 32'h0000_001F);
    drive(32'h0000_1008, 32'h1, 32'h2, 32'h0000_0405, 5'd3, 1'b0, 1'b1, 3'b101, 1'b1);
    step();
    chk("nonalu_is_shift", out_is_shift, 0);
    chk("nonalu_shtype", out_shtype, 0);
    // SRL register form: shamt from rs2 low bits
    drive(32'h0000_100C, 32'h1, 32'hFFFF_FFE3, 32'h0000_0405, 5'd4, 1'b1, 1'b0, 3'b101, 1'b0);
    step();
    in_valid = 1'b0;
    chk("srl_shamt", out_shamt, 3);
    chk("srl_shtype", out_shtype, 2'b00);
    chk("srl_b", out_b, 32'hFFFF_FFE3);
    step();
    chk("srl_drained", out_valid, 0);

    // 3. backpressure: A into main, B into skid
    out_ready = 1'b0;
    drive(32'h0000_0100, 32'h0, 32'd3, 32'h0, 5'd1, 1'b1, 1'b0, 3'b001, 1'b0);
    step();
    chk("bp_a_valid", out_valid, 1);
    chk("bp_ready_after_a", in_ready, 1);
    drive(32'h0000_0104, 32'h0, 32'h0000_0025, 32'h0, 5'd2, 1'b1, 1'b0, 3'b101, 1'b0);
    step();
    in_valid = 1'b0;
    chk("bp_ready_after_b", in_ready, 0);
    chk("bp_main_is_a", out_pc, 32'h0000_0100);
    chk("bp_a_shamt", out_shamt, 3);
    step();
    chk("bp_hold_a", out_pc, 32'h0000_0100);
    out_ready = 1'b1;
    step();
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_pc", out_pc, 32'h0000_0104);
    chk("bp_b_shamt", out_shamt, 5);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // 4. flush with both entries full and an incoming instruction
    out_ready = 1'b0;
    drive(32'h0000_0200, 32'h0, 32'd1, 32'h0, 5'd1, 1'b1, 1'b0, 3'b001, 1'b0);
    step();
    drive(32'h0000_0204, 32'h0, 32'd2, 32'h0, 5'd1, 1'b1, 1'b0, 3'b001, 1'b0);
    step();
    chk("fl_full", in_ready, 0);
    drive(32'h0000_0208, 32'h0, 32'd3, 32'h0, 5'd1, 1'b1, 1'b0, 3'b001, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("fl_nothing_left", out_valid, 0);
    // flush beats a simultaneous accepted input
    drive(32'h0000_020C, 32'h0, 32'd4, 32'h0, 5'd1, 1'b1, 1'b0, 3'b001, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_in_fire_dropped", out_valid, 0);
    step();
    chk("fl_in_fire_dropped2", out_valid, 0);

    // 5. eight back-to-back SLLs
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(32'h0000_0300 + 32'(i * 4), 32'h1, 32'(i), 32'h0, 5'(i), 1'b1, 1'b0, 3'b001, 1'b0);
      step();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_pc", out_pc, 32'h0000_0300 + 32'(i * 4));
      chk("b2b_shamt", out_shamt, 32'(i));
      chk("b2b_shtype", out_shtype, 2'b01);
      chk("b2b_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_done", out_valid, 0);

    // Reset mid-stream: held entry lost, nothing emitted afterwards
    out_ready = 1'b0;
    drive(32'h0000_0400, 32'h0, 32'd1, 32'h0, 5'd1, 1'b1, 1'b0, 3'b001, 1'b0);
    step();
    in_valid = 1'b0;
    chk("mid_rst_pre", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pc", out_pc, 0);
    step();
    chk("mid_rst_after", out_valid, 0);

`ifdef ID_EX_STALL_CNT_EN
    // 6. three stall cycles then one flush (counters zeroed by the reset above)
    chk("cnt_reset_stall", stall_cnt, 0);
    chk("cnt_reset_flush", flush_cnt, 0);
    drive(32'h0000_0500, 32'h0, 32'd1, 32'h0, 5'd1, 1'b1, 1'b0, 3'b001, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("cnt_stall3", stall_cnt, 3);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("cnt_stall_final", stall_cnt, 3);
    chk("cnt_flush", flush_cnt, 1);
    step();
    chk("cnt_flush_hold", flush_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
